// File: rtl/beam_mask_apply_pkg.sv
// Shared constants, FSM state type and helpers for the beam mask apply block.
package beam_mask_apply_pkg;

    localparam int NBEAMS_DEFAULT = 48;
    localparam int LO_BEAMS       = 18;
    localparam int HI_BEAMS       = 30;
    localparam int CNT_W          = 16;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } bm_state_e;

    // Saturating increment for the masked-beat counter.
    function automatic logic [CNT_W-1:0] sat_inc16(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/beam_mask_stage.sv
// Staging/active mask registers and the IDLE/PENDING apply FSM; exports the
// mask that governs the current beat.
module beam_mask_stage
    import beam_mask_apply_pkg::*;
#(
    parameter int                 NBEAMS    = NBEAMS_DEFAULT,
    parameter logic [NBEAMS-1:0]  INIT_MASK = {NBEAMS{1'b1}}
) (
    input  logic              ifclk,
    input  logic              ifclk_rst_i,
    input  logic [NBEAMS-1:0] beam_mask_i,
    input  logic [1:0]        beam_mask_wr_i,
    input  logic              beam_mask_update_i,
    input  logic              frame_i,
    output logic [NBEAMS-1:0] mask_active_o,
    output logic [NBEAMS-1:0] mask_eff_o,
    output logic              update_pending_o
);

    logic [NBEAMS-1:0] staging_r;
    logic [NBEAMS-1:0] active_r;
    bm_state_e         state_r;
    bm_state_e         state_nxt_s;
    logic              apply_s;

    // Next-state decode; an update seen in PENDING is deliberately ignored.
    always_comb begin
        state_nxt_s = state_r;
        apply_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (beam_mask_update_i) begin
                    state_nxt_s = ST_PENDING;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (frame_i) begin
                    state_nxt_s = ST_IDLE;
                    apply_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_PENDING;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                apply_s     = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge ifclk) begin
        if (ifclk_rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Staging mask: each group has its own write strobe.
    always_ff @(posedge ifclk) begin
        if (ifclk_rst_i) begin
            staging_r <= INIT_MASK;
        end else begin
            if (beam_mask_wr_i[0]) begin
                staging_r[LO_BEAMS-1:0] <= beam_mask_i[LO_BEAMS-1:0];
            end
            if (beam_mask_wr_i[1]) begin
                staging_r[NBEAMS-1:LO_BEAMS] <= beam_mask_i[NBEAMS-1:LO_BEAMS];
            end
        end
    end

    // Active mask: copies the pre-edge staging value, so a coincident write misses it.
    always_ff @(posedge ifclk) begin
        if (ifclk_rst_i) begin
            active_r <= INIT_MASK;
        end else if (apply_s) begin
            active_r <= staging_r;
        end else begin
            active_r <= active_r;
        end
    end

    // The frame beat that triggers an apply is already filtered by the new mask.
    always_comb begin
        if ((state_r == ST_PENDING) && frame_i) begin
            mask_eff_o = staging_r;
        end else begin
            mask_eff_o = active_r;
        end
    end

    assign mask_active_o    = active_r;
    assign update_pending_o = (state_r == ST_PENDING);

endmodule

// File: rtl/beam_mask_apply.sv
// Applies a frame-synchronised per-beam mask to the trigger stream (1-cycle latency).
// Optional masked-beat counter is built when MASKED_COUNT_EN is defined.
module beam_mask_apply
    import beam_mask_apply_pkg::*;
#(
    parameter int                 NBEAMS    = NBEAMS_DEFAULT,
    parameter logic [NBEAMS-1:0]  INIT_MASK = {NBEAMS{1'b1}}
) (
    input  logic              ifclk,
    input  logic              ifclk_rst_i,
    input  logic [NBEAMS-1:0] beam_mask_i,
    input  logic [1:0]        beam_mask_wr_i,
    input  logic              beam_mask_update_i,
    input  logic              frame_i,
    input  logic [NBEAMS-1:0] trig_i,
    input  logic              trig_valid_i,
    output logic [NBEAMS-1:0] trig_o,
    output logic              trig_valid_o,
    output logic [NBEAMS-1:0] mask_active_o,
    output logic              update_pending_o
`ifdef MASKED_COUNT_EN
    ,
    input  logic              count_clr_i,
    output logic [CNT_W-1:0]  masked_count_o
`endif
);

    logic [NBEAMS-1:0] mask_eff_s;
    logic [NBEAMS-1:0] trig_masked_s;
    logic [NBEAMS-1:0] trig_r;
    logic              trig_valid_r;

    beam_mask_stage #(
        .NBEAMS    (NBEAMS),
        .INIT_MASK (INIT_MASK)
    ) u_stage (
        .ifclk              (ifclk),
        .ifclk_rst_i        (ifclk_rst_i),
        .beam_mask_i        (beam_mask_i),
        .beam_mask_wr_i     (beam_mask_wr_i),
        .beam_mask_update_i (beam_mask_update_i),
        .frame_i            (frame_i),
        .mask_active_o      (mask_active_o),
        .mask_eff_o         (mask_eff_s),
        .update_pending_o   (update_pending_o)
    );

    // Masked beat; invalid beats are zeroed so downstream never sees stale bits.
    always_comb begin
        if (trig_valid_i) begin
            trig_masked_s = trig_i & ~mask_eff_s;
        end else begin
            trig_masked_s = {NBEAMS{1'b0}};
        end
    end

    // Output pipeline register.
    always_ff @(posedge ifclk) begin
        if (ifclk_rst_i) begin
            trig_r       <= {NBEAMS{1'b0}};
            trig_valid_r <= 1'b0;
        end else begin
            trig_r       <= trig_masked_s;
            trig_valid_r <= trig_valid_i;
        end
    end

    assign trig_o       = trig_r;
    assign trig_valid_o = trig_valid_r;

`ifdef MASKED_COUNT_EN
    logic             hit_s;
    logic [CNT_W-1:0] count_r;

    // A beat counts when any raw trigger bit was suppressed by the mask.
    always_comb begin
        if (trig_valid_i) begin
            hit_s = |(trig_i & mask_eff_s);
        end else begin
            hit_s = 1'b0;
        end
    end

    // Saturating counter; clear wins over a same-cycle hit.
    always_ff @(posedge ifclk) begin
        if (ifclk_rst_i) begin
            count_r <= 16'h0000;
        end else if (count_clr_i) begin
            count_r <= 16'h0000;
        end else if (hit_s) begin
            count_r <= sat_inc16(count_r);
        end else begin
            count_r <= count_r;
        end
    end

    assign masked_count_o = count_r;
`endif

endmodule

// File: doc/beam_mask_apply.md
BEAM_MASK_APPLY -- requirements
Module: beam_mask_apply

Interface
REQ-001 Parameter NBEAMS, default 48: number of beams; the low group is fixed at 18 beams and the high group is NBEAMS-18 beams.
REQ-002 Parameter INIT_MASK, default all ones: value of the staging and active masks after reset; a mask bit of 1 means the beam is masked.
REQ-003 Port ifclk, input, 1 bit: the only clock; all logic runs on its rising edge.
REQ-004 Port ifclk_rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port beam_mask_i, input, NBEAMS bits: quasi-static mask data from the wishbone core; sampled only when a write strobe is high.
REQ-006 Port beam_mask_wr_i, input, 2 bits: bit 0 is the low-group (bits 17:0) write strobe; bit 1 is the high-group (bits 47:18) write strobe.
REQ-007 Port beam_mask_update_i, input, 1 bit: request to apply the staged mask.
REQ-008 Port frame_i, input, 1 bit: frame-boundary pulse; high on the first beat of each frame.
REQ-009 Port trig_i, input, NBEAMS bits: raw per-beam trigger beat.
REQ-010 Port trig_valid_i, input, 1 bit: trig_i qualifier.
REQ-011 Port trig_o, output, NBEAMS bits: masked trigger beat.
REQ-012 Port trig_valid_o, output, 1 bit: trig_o qualifier.
REQ-013 Port mask_active_o, output, NBEAMS bits: the mask currently in effect.
REQ-014 Port update_pending_o, output, 1 bit: high while the FSM is in PENDING.
REQ-015 Port count_clr_i, input, 1 bit; present only with the macro in REQ-031.
REQ-016 Port masked_count_o, output, 16 bits; present only with the macro in REQ-031.

Function
REQ-017 A cycle with beam_mask_wr_i[0]=1 shall load staging[17:0] from beam_mask_i[17:0]; a cycle with beam_mask_wr_i[1]=1 shall load staging[47:18] from beam_mask_i[47:18]; both strobes in one cycle shall load both groups.
REQ-018 The FSM shall have two states, IDLE and PENDING.
REQ-019 FSM transitions:
- IDLE to PENDING when beam_mask_update_i=1.
- PENDING to IDLE when frame_i=1; on that transition, active is loaded from staging.
REQ-020 beam_mask_update_i in PENDING shall have no effect, and the FSM shall stay in PENDING.
REQ-021 beam_mask_update_i and frame_i high together in IDLE shall enter PENDING without applying; the apply happens at the next frame_i.
REQ-022 A staging write in the same cycle as an apply shall not reach active; the apply copies the staging value held before that edge.
REQ-023 The effective mask for a beat shall be the staging value if (state==PENDING and frame_i=1), otherwise active.
- The first beat of a frame is therefore already filtered by the new mask.
REQ-024 trig_o shall be registered as trig_i AND NOT effective mask, and trig_valid_o registered from trig_valid_i.
- Latency is exactly 1 cycle.
- trig_o is forced to zero when trig_valid_i=0.
REQ-025 mask_active_o shall equal the active register; the active mask never changes except at a frame boundary.

Reset
REQ-026 While ifclk_rst_i=1 at a clock edge:
- staging and active become INIT_MASK;
- the state becomes IDLE;
- trig_o, trig_valid_o and update_pending_o become 0;
- masked_count_o becomes 0.
REQ-027 Reset shall take priority over write, update, apply and count events in the same cycle; a pending update is discarded.
REQ-028 The first beat after reset is released shall be processed normally.

Configuration
REQ-029 With MASKED_COUNT_EN defined, a 16-bit counter shall increment once per beat with trig_valid_i=1 and (trig_i AND effective mask) nonzero.
REQ-030 The counter shall saturate at 16'hFFFF, and count_clr_i shall zero it with priority over a same-cycle increment.
REQ-031 Without MASKED_COUNT_EN, the count_clr_i and masked_count_o ports and the counter logic shall be absent.

Structure
REQ-032 A shared package shall hold NBEAMS_DEFAULT=48, LO_BEAMS=18, HI_BEAMS=30 and the two-state FSM enum type.
REQ-033 One sub-module, beam_mask_stage, shall hold the staging registers, the FSM and the active register, and shall export the effective mask; the top level shall hold the output pipeline and the counter.

Verification
REQ-034 Reset released -> trig_i=all ones with valid gives trig_o=0 one cycle later (INIT_MASK all ones).
REQ-035 Write low group 18'h00001 and high group 30'h0, then update, then frame_i -> trig_i=all ones in the frame_i beat gives trig_o=48'hFFFF_FFFF_FFFE; mask_active_o unchanged before the frame.
REQ-036 update and frame_i high in the same cycle in IDLE -> mask_active_o unchanged; update_pending_o=1; the apply occurs at the next frame_i.
REQ-037 Write strobe coincident with the apply -> active takes the old staging value; the new value is applied only after a further update plus frame_i.
REQ-038 MASKED_COUNT_EN: 70000 fully masked valid beats -> masked_count_o=16'hFFFF; count_clr_i asserted during a masked beat -> 0.
REQ-039 Reset asserted while in PENDING -> update_pending_o=0 and active=INIT_MASK; a later frame_i applies nothing.
